// File: rtl/synchronizer_filtered.sv
// rtl/synchronizer_filtered.sv - multi-channel async input synchronizer with glitch filter
// and rise/fall pulses on the filtered level.
module synchronizer_filtered #(
  parameter int                 NB_DATA     = 1,
  parameter int                 N_STAGES    = 2,
  parameter int                 FILTER_LEN  = 0,
  parameter int                 NB_FILTER   = 4,
  parameter logic [NB_DATA-1:0] RESET_VALUE = '0
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_enable,
  output logic [NB_DATA-1:0] o_sync,
  output logic [NB_DATA-1:0] o_data,
  output logic [NB_DATA-1:0] o_rise,
  output logic [NB_DATA-1:0] o_fall
);

  if (N_STAGES < 2) begin : g_bad_stages
    $error("synchronizer_filtered: N_STAGES must be >= 2");
  end
  if (FILTER_LEN >= (1 << NB_FILTER)) begin : g_bad_filter
    $error("synchronizer_filtered: FILTER_LEN must be < 2**NB_FILTER");
  end

  // Counter value at which a pending change is accepted; FILTER_LEN of 0 and 1 both mean "next edge".
  localparam int                   LAST_INT = (FILTER_LEN > 1) ? FILTER_LEN - 1 : 0;
  localparam logic [NB_FILTER-1:0] CNT_LAST = NB_FILTER'(LAST_INT);

  logic [NB_DATA-1:0]   chain [N_STAGES];
  logic [NB_FILTER-1:0] cnt   [NB_DATA];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < N_STAGES; i++) chain[i] <= RESET_VALUE;
    end else begin
      chain[0] <= i_data;
      for (int i = 1; i < N_STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign o_sync = chain[N_STAGES-1];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data <= RESET_VALUE;
      o_rise <= '0;
      o_fall <= '0;
      for (int c = 0; c < NB_DATA; c++) cnt[c] <= '0;
    end else begin
      o_rise <= '0;
      o_fall <= '0;
      if (i_enable) begin
        for (int c = 0; c < NB_DATA; c++) begin
          if (o_sync[c] == o_data[c]) begin
            cnt[c] <= '0;
          end else if (cnt[c] == CNT_LAST) begin
            o_data[c] <= o_sync[c];
            o_rise[c] <= o_sync[c];
            o_fall[c] <= ~o_sync[c];
            cnt[c]    <= '0;
          end else begin
            cnt[c] <= cnt[c] + NB_FILTER'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_synchronizer_filtered.sv
// tb/tb_synchronizer_filtered.sv - randomized and directed bench for synchronizer_filtered
// against a run-length reference model.
module tb_synchronizer_filtered;

  localparam logic [3:0] RV_A = 4'b1010;
  localparam logic [3:0] RV_B = 4'b0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en;
  logic [3:0] a_in, b_in;
  logic [3:0] a_sync, a_data, a_rise, a_fall;
  logic [3:0] b_sync, b_data, b_rise, b_fall;

  int n_tests = 0;
  int n_fail  = 0;

  synchronizer_filtered #(
    .NB_DATA(4), .N_STAGES(2), .FILTER_LEN(0), .NB_FILTER(4), .RESET_VALUE(RV_A)
  ) dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_data(a_in), .i_enable(en),
    .o_sync(a_sync), .o_data(a_data), .o_rise(a_rise), .o_fall(a_fall)
  );

  synchronizer_filtered #(
    .NB_DATA(4), .N_STAGES(3), .FILTER_LEN(4), .NB_FILTER(4), .RESET_VALUE(RV_B)
  ) dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_data(b_in), .i_enable(en),
    .o_sync(b_sync), .o_data(b_data), .o_rise(b_rise), .o_fall(b_fall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: o_sync is the input seen N edges ago; o_data flips once the
  // synchronized level has disagreed with it for L consecutive enabled edges.
  logic [3:0] hist [2][8];
  int         run  [2][4];
  logic [3:0] md [2], mr [2], mf [2];
  int         since [2][4];
  logic [3:0] prev [2];

  function automatic int ns(input int k);
    return (k == 0) ? 2 : 3;
  endfunction
  function automatic int ll(input int k);
    return (k == 0) ? 1 : 4;
  endfunction
  function automatic logic [3:0] rv(input int k);
    return (k == 0) ? RV_A : RV_B;
  endfunction

  task automatic model_reset(input int k);
    for (int i = 0; i < 8; i++) hist[k][i] = rv(k);
    for (int c = 0; c < 4; c++) begin
      run[k][c]   = 0;
      since[k][c] = 100;
    end
    md[k] = rv(k); mr[k] = '0; mf[k] = '0; prev[k] = rv(k);
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        model_reset(k);
      end else begin
        logic [3:0] s;
        s = hist[k][ns(k)-1];
        mr[k] = '0;
        mf[k] = '0;
        if (en) begin
          for (int c = 0; c < 4; c++) begin
            if (s[c] == md[k][c]) run[k][c] = 0;
            else begin
              run[k][c]++;
              if (run[k][c] >= ll(k)) begin
                md[k][c] = s[c];
                if (s[c]) mr[k][c] = 1'b1; else mf[k][c] = 1'b1;
                run[k][c] = 0;
              end
            end
          end
        end
        for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = (k == 0) ? a_in : b_in;
      end
    end
  endtask

  task automatic min_width(input int k, input logic [3:0] cur);
    for (int c = 0; c < 4; c++) begin
      since[k][c]++;
      if (cur[c] !== prev[k][c]) begin
        check(k == 0 ? "minw_a" : "minw_b", 32'(since[k][c] >= ll(k)), 32'd1);
        since[k][c] = 0;
      end
    end
    prev[k] = cur;
  endtask

  task automatic compare();
    check("sync_a", a_sync, hist[0][1]);
    check("data_a", a_data, md[0]);
    check("rise_a", a_rise, mr[0]);
    check("fall_a", a_fall, mf[0]);
    check("sync_b", b_sync, hist[1][2]);
    check("data_b", b_data, md[1]);
    check("rise_b", b_rise, mr[1]);
    check("fall_b", b_fall, mf[1]);
    check("excl_a", a_rise & a_fall, 32'd0);
    check("excl_b", b_rise & b_fall, 32'd0);
    min_width(0, a_data);
    min_width(1, b_data);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Asserts reset between edges, checks it acts at once, holds it over two edges, releases at a negedge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check("rst_now_data_a", a_data, RV_A);
    check("rst_now_data_b", b_data, RV_B);
    check("rst_now_sync_b", b_sync, RV_B);
    check("rst_now_pulse", {a_rise, a_fall, b_rise, b_fall}, 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int nr, hi, at;
    logic [3:0] m;
    rst_n = 1'b0;
    en    = 1'b1;
    a_in  = RV_A;
    b_in  = RV_B;
    #1;
    model_reset(0);
    model_reset(1);
    cycle();
    check("reset_data_a", a_data, 32'hA);
    check("reset_sync_a", a_sync, 32'hA);
    check("reset_data_b", b_data, 32'h0);
    cycle();
    rst_n = 1'b1;

    // 1: unfiltered 0->1 on channel 0
    a_in = 4'b1011;
    cycle(); check("t1_e0_sync", a_sync, 32'hA);
    cycle(); check("t1_e1_sync", a_sync, 32'hB); check("t1_e1_data", a_data, 32'hA);
    cycle(); check("t1_e2_data", a_data, 32'hB); check("t1_e2_rise", a_rise, 32'h1);
    cycle(); check("t1_e3_rise", a_rise, 32'h0);

    // 5: multi-bit rise and fall on the same edge from the reset level
    a_in = 4'b1010;
    do_reset();
    check("t5_after_rst", a_data, 32'hA);
    a_in = 4'b0101;
    cycle(); cycle(); cycle();
    check("t5_rise", a_rise, 32'h5);
    check("t5_fall", a_fall, 32'hA);
    check("t5_data", a_data, 32'h5);

    // 2: 3-cycle glitch rejected, then a held level accepted exactly once
    b_in = 4'b0001;
    nr = 0; hi = 0;
    for (int i = 0; i < 3; i++) begin cycle(); nr += int'(b_rise[0]); hi += int'(b_data[0]); end
    b_in = 4'b0000;
    for (int i = 0; i < 10; i++) begin cycle(); nr += int'(b_rise[0]); hi += int'(b_data[0]); end
    check("t2_glitch_rise", nr, 0);
    check("t2_glitch_data", hi, 0);
    b_in = 4'b0001;
    nr = 0; at = -1;
    for (int e = 0; e < 12; e++) begin
      cycle();
      if (b_rise[0]) begin nr++; at = e; end
    end
    check("t2_rise_count", nr, 1);
    check("t2_rise_edge", at, 6);

    // 3: enable dropped with cnt=2, flip lands on the second re-enabled edge
    b_in = 4'b0000;
    for (int i = 0; i < 12; i++) cycle();
    check("t3_start", b_data[0], 1'b0);
    b_in = 4'b0001;
    for (int e = 0; e < 5; e++) cycle();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t3_hold_data", b_data[0], 1'b0);
      check("t3_hold_pulse", {b_rise[0], b_fall[0]}, 32'd0);
    end
    en = 1'b1;
    cycle(); check("t3_re1_data", b_data[0], 1'b0);
    cycle(); check("t3_re2_data", b_data[0], 1'b1); check("t3_re2_rise", b_rise[0], 1'b1);

    // 4: reset while o_data=1, release with input high
    do_reset();
    for (int e = 0; e <= 6; e++) begin
      cycle();
      check(e < 6 ? "t4_no_rise" : "t4_rise", b_rise[0], e == 6);
    end

    // 6: random traffic with occasional enable drops and resets
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 1999) == 0) do_reset();
      m = '0;
      for (int c = 0; c < 4; c++) m[c] = ($urandom_range(0, 7) == 0);
      a_in = a_in ^ m;
      m = '0;
      for (int c = 0; c < 4; c++) m[c] = ($urandom_range(0, 5) == 0);
      b_in = b_in ^ m;
      en = ($urandom_range(0, 15) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
